// File: rtl/scan_seq_pkg.sv
// Shared state encoding and constants for scan_sequencer and its pulse generators.
package scan_seq_pkg;

  localparam int DEJITTER_TAPS = 8;

  typedef enum logic [3:0] {
    IDLE,
    LATCH,
    GALVO_PULSE,
    WAIT_GALVO,
    WAIT_SETTLE,
    CAM_WAIT_READY,
    CAM_PULSE,
    COUNT_CYCLES,
    NEXT_IMG,
    NEXT_POS,
    FINISH
  } scan_state_e;

endpackage

// File: rtl/scan_sequencer_ms_pulse_gen.sv
// ms_pulse_gen: one-shot pulse of ms*CLK_KHZ clock cycles; a new start restarts
// the count and clear truncates any pulse in flight.
module ms_pulse_gen #(
  parameter int MS_W    = 8,
  parameter int CLK_KHZ = 50000
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            start,
  input  logic            clear,
  input  logic [MS_W-1:0] ms,
  output logic            pulse
);

  localparam int CNT_W = MS_W + $clog2(CLK_KHZ + 1);

  logic [CNT_W-1:0] cnt, cnt_n;

  always_comb begin
    cnt_n = cnt;
    if (clear)
      cnt_n = '0;
    else if (start)
      cnt_n = CNT_W'(ms) * CNT_W'(CLK_KHZ);
    else if (cnt != '0)
      cnt_n = cnt - CNT_W'(1);
  end

  // pulse is registered from the next count so it is high for exactly the loaded count
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      cnt   <= cnt_n;
      pulse <= (cnt_n != '0);
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: steps SLM images (and optionally galvo positions) on VGA frame syncs,
// firing camera and galvo pulses. Define SCAN_SEQ_CAM_READY_EN to gate the camera on iCAMERA_READY.
module scan_sequencer
  import scan_seq_pkg::*;
#(
  parameter int IMG_W   = 7,
  parameter int CYC_W   = 16,
  parameter int POS_W   = 32,
  parameter int MS_W    = 8,
  parameter int CLK_KHZ = 50000
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [MS_W-1:0]  iCAMERA_TRIGGER_MILLISEC,
  input  logic [MS_W-1:0]  iGALVO_TRIGGER_MILLISEC,
  input  logic [IMG_W-1:0] iNUM_SLM_IMAGES,
  input  logic [CYC_W-1:0] iCYCLES_PER_IMAGE,
  input  logic [POS_W-1:0] iNUM_GALVO_POSITIONS,
  input  logic [3:0]       iSETTLE_FRAMES,
  input  logic             iTRIG_WITH_GALVO,
  input  logic             iTRIG_WITHOUT_GALVO,
  input  logic             iABORT,
  input  logic             iGALVO_ACK,
  input  logic             iVGA_FRAME_SYNC,
`ifdef SCAN_SEQ_CAM_READY_EN
  input  logic             iCAMERA_READY,
`endif
  output logic             oCAMERA_TRIGGER,
  output logic             oGALVO_CHANGE_TRIGGER,
  output logic [IMG_W-1:0] oCURRENT_DISPLAY_FRAME_ID,
  output logic [POS_W-1:0] oGALVO_POSITION,
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oABORTED
);

  scan_state_e state, state_n;
  logic mode_galvo, mode_galvo_n;
  logic [IMG_W-1:0] img_total, img_cnt, img_cnt_n;
  logic [CYC_W-1:0] cyc_total, cyc_cnt, cyc_cnt_n;
  logic [POS_W-1:0] pos_total, pos_cnt, pos_cnt_n;
  logic [3:0] settle;
  logic [MS_W-1:0] cam_ms, galvo_ms;
  logic [4:0] sync_cnt, sync_cnt_n, sync_next, sync_target;
  logic ack_seen, ack_seen_n;
  logic syncs_done, img_last, cyc_last, pos_last;
  logic abort_now, cam_ready;
  logic [DEJITTER_TAPS-1:0] sync_taps;
  logic sync_filt_q, sync_evt;

`ifdef SCAN_SEQ_CAM_READY_EN
  assign cam_ready = iCAMERA_READY;
`else
  assign cam_ready = 1'b1;
`endif

  // A sync event is the falling edge of the OR of the last eight raw samples,
  // so short low glitches inside a sync pulse never produce an event.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sync_taps   <= '0;
      sync_filt_q <= 1'b0;
      sync_evt    <= 1'b0;
    end else begin
      sync_taps   <= {sync_taps[DEJITTER_TAPS-2:0], iVGA_FRAME_SYNC};
      sync_filt_q <= |sync_taps;
      sync_evt    <= sync_filt_q & ~(|sync_taps);
    end
  end

  assign abort_now   = iABORT && (state != IDLE);
  assign sync_target = 5'(settle) + 5'd1;
  assign sync_next   = (sync_evt && (sync_cnt < sync_target)) ? sync_cnt + 5'd1 : sync_cnt;
  assign syncs_done  = (sync_next >= sync_target);
  assign img_last    = ({1'b0, img_cnt} + (IMG_W+1)'(1)) == {1'b0, img_total};
  assign cyc_last    = ({1'b0, cyc_cnt} + (CYC_W+1)'(1)) == {1'b0, cyc_total};
  assign pos_last    = ({1'b0, pos_cnt} + (POS_W+1)'(1)) == {1'b0, pos_total};

  always_comb begin
    state_n      = state;
    mode_galvo_n = mode_galvo;
    img_cnt_n    = img_cnt;
    cyc_cnt_n    = cyc_cnt;
    pos_cnt_n    = pos_cnt;
    sync_cnt_n   = '0;
    ack_seen_n   = 1'b0;
    case (state)
      IDLE:
        if (iTRIG_WITH_GALVO || iTRIG_WITHOUT_GALVO) begin
          state_n      = LATCH;
          mode_galvo_n = iTRIG_WITH_GALVO;
        end
      LATCH: begin
        img_cnt_n = '0;
        cyc_cnt_n = '0;
        pos_cnt_n = '0;
        if ((iNUM_SLM_IMAGES == '0) || (iCYCLES_PER_IMAGE == '0) ||
            (mode_galvo && (iNUM_GALVO_POSITIONS == '0)))
          state_n = FINISH;
        else
          state_n = mode_galvo ? GALVO_PULSE : WAIT_SETTLE;
      end
      GALVO_PULSE:
        state_n = WAIT_GALVO;
      WAIT_GALVO: begin
        sync_cnt_n = sync_next;
        ack_seen_n = ack_seen | iGALVO_ACK;
        if (ack_seen_n && syncs_done)
          state_n = CAM_WAIT_READY;
      end
      WAIT_SETTLE: begin
        sync_cnt_n = sync_next;
        if (syncs_done)
          state_n = CAM_WAIT_READY;
      end
      CAM_WAIT_READY:
        if (cam_ready)
          state_n = CAM_PULSE;
      CAM_PULSE:
        state_n = COUNT_CYCLES;
      COUNT_CYCLES:
        if (sync_evt) begin
          if (cyc_last)
            state_n = NEXT_IMG;
          else
            cyc_cnt_n = cyc_cnt + CYC_W'(1);
        end
      NEXT_IMG: begin
        cyc_cnt_n = '0;
        if (img_last)
          state_n = mode_galvo ? NEXT_POS : FINISH;
        else begin
          img_cnt_n = img_cnt + IMG_W'(1);
          state_n   = WAIT_SETTLE;
        end
      end
      NEXT_POS:
        if (pos_last)
          state_n = FINISH;
        else begin
          pos_cnt_n = pos_cnt + POS_W'(1);
          img_cnt_n = '0;
          state_n   = GALVO_PULSE;
        end
      FINISH:
        state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
    // abort overrides whatever the state decoded above
    if (abort_now) begin
      state_n   = IDLE;
      img_cnt_n = '0;
      cyc_cnt_n = '0;
      pos_cnt_n = '0;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state      <= IDLE;
      mode_galvo <= 1'b0;
      img_cnt    <= '0;
      cyc_cnt    <= '0;
      pos_cnt    <= '0;
      sync_cnt   <= '0;
      ack_seen   <= 1'b0;
      img_total  <= '0;
      cyc_total  <= '0;
      pos_total  <= '0;
      settle     <= '0;
      cam_ms     <= '0;
      galvo_ms   <= '0;
      oDONE      <= 1'b0;
      oABORTED   <= 1'b0;
    end else begin
      state      <= state_n;
      mode_galvo <= mode_galvo_n;
      img_cnt    <= img_cnt_n;
      cyc_cnt    <= cyc_cnt_n;
      pos_cnt    <= pos_cnt_n;
      sync_cnt   <= sync_cnt_n;
      ack_seen   <= ack_seen_n;
      oDONE      <= (state == FINISH) && !abort_now;
      oABORTED   <= abort_now;
      if (state == LATCH) begin
        img_total <= iNUM_SLM_IMAGES;
        cyc_total <= iCYCLES_PER_IMAGE;
        pos_total <= iNUM_GALVO_POSITIONS;
        settle    <= iSETTLE_FRAMES;
        cam_ms    <= iCAMERA_TRIGGER_MILLISEC;
        galvo_ms  <= iGALVO_TRIGGER_MILLISEC;
      end
    end
  end

  assign oCURRENT_DISPLAY_FRAME_ID = img_cnt;
  assign oGALVO_POSITION           = pos_cnt;
  assign oBUSY                     = (state != IDLE);

  ms_pulse_gen #(.MS_W(MS_W), .CLK_KHZ(CLK_KHZ)) u_cam_pulse (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .start (state == CAM_PULSE),
    .clear (abort_now),
    .ms    (cam_ms),
    .pulse (oCAMERA_TRIGGER)
  );

  ms_pulse_gen #(.MS_W(MS_W), .CLK_KHZ(CLK_KHZ)) u_galvo_pulse (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .start (state == GALVO_PULSE),
    .clear (abort_now),
    .ms    (galvo_ms),
    .pulse (oGALVO_CHANGE_TRIGGER)
  );

endmodule

// File: tb/tb_scan_sequencer.sv
// Table-driven bench for scan_sequencer with hand-written sequences for
// zero-count timing, abort, settle, sync glitch and camera-ready gating.
`timescale 1ns/1ps
module tb_scan_sequencer;

  localparam int IMG_W       = 7;
  localparam int CYC_W       = 16;
  localparam int POS_W       = 32;
  localparam int MS_W        = 8;
  localparam int CLK_KHZ     = 10;
  localparam int SYNC_PERIOD = 200;
  localparam int SYNC_HIGH   = 20;
  localparam int ACK_DELAY   = 500;
  localparam int RUN_TIMEOUT = 20000;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  logic [MS_W-1:0]  iCAMERA_TRIGGER_MILLISEC = '0;
  logic [MS_W-1:0]  iGALVO_TRIGGER_MILLISEC = '0;
  logic [IMG_W-1:0] iNUM_SLM_IMAGES = '0;
  logic [CYC_W-1:0] iCYCLES_PER_IMAGE = '0;
  logic [POS_W-1:0] iNUM_GALVO_POSITIONS = '0;
  logic [3:0]       iSETTLE_FRAMES = '0;
  logic iTRIG_WITH_GALVO = 1'b0;
  logic iTRIG_WITHOUT_GALVO = 1'b0;
  logic iABORT = 1'b0;
  logic iGALVO_ACK = 1'b0;
  logic iVGA_FRAME_SYNC = 1'b0;
`ifdef SCAN_SEQ_CAM_READY_EN
  logic iCAMERA_READY = 1'b1;
`endif
  logic oCAMERA_TRIGGER, oGALVO_CHANGE_TRIGGER, oBUSY, oDONE, oABORTED;
  logic [IMG_W-1:0] oCURRENT_DISPLAY_FRAME_ID;
  logic [POS_W-1:0] oGALVO_POSITION;

  scan_sequencer #(
    .IMG_W(IMG_W), .CYC_W(CYC_W), .POS_W(POS_W), .MS_W(MS_W), .CLK_KHZ(CLK_KHZ)
  ) dut (
    .iCLK                      (iCLK),
    .iRST                      (iRST),
    .iCAMERA_TRIGGER_MILLISEC  (iCAMERA_TRIGGER_MILLISEC),
    .iGALVO_TRIGGER_MILLISEC   (iGALVO_TRIGGER_MILLISEC),
    .iNUM_SLM_IMAGES           (iNUM_SLM_IMAGES),
    .iCYCLES_PER_IMAGE         (iCYCLES_PER_IMAGE),
    .iNUM_GALVO_POSITIONS      (iNUM_GALVO_POSITIONS),
    .iSETTLE_FRAMES            (iSETTLE_FRAMES),
    .iTRIG_WITH_GALVO          (iTRIG_WITH_GALVO),
    .iTRIG_WITHOUT_GALVO       (iTRIG_WITHOUT_GALVO),
    .iABORT                    (iABORT),
    .iGALVO_ACK                (iGALVO_ACK),
    .iVGA_FRAME_SYNC           (iVGA_FRAME_SYNC),
`ifdef SCAN_SEQ_CAM_READY_EN
    .iCAMERA_READY             (iCAMERA_READY),
`endif
    .oCAMERA_TRIGGER           (oCAMERA_TRIGGER),
    .oGALVO_CHANGE_TRIGGER     (oGALVO_CHANGE_TRIGGER),
    .oCURRENT_DISPLAY_FRAME_ID (oCURRENT_DISPLAY_FRAME_ID),
    .oGALVO_POSITION           (oGALVO_POSITION),
    .oBUSY                     (oBUSY),
    .oDONE                     (oDONE),
    .oABORTED                  (oABORTED)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [1:0] trig;
    int images, cycles, positions, settle, cam_ms, galvo_ms;
    int exp_cam, exp_galvo, exp_cam_len, exp_galvo_len, exp_frame, exp_pos;
  } run_vec_t;

  run_vec_t vecs[8];

  int check_count = 0;
  int pass_count  = 0;
  int cam_rise, galvo_rise, cam_len, galvo_len, cam_bad, galvo_bad, cam_early;
  int done_cnt, aborted_cnt, sync_falls, sync_phase;
  int exp_cam_len, exp_galvo_len;
  logic cam_prev, galvo_prev, ack_galvo_prev, ack_pending, sync_en;

  initial begin
    cam_rise = 0; galvo_rise = 0; cam_len = 0; galvo_len = 0; cam_bad = 0; galvo_bad = 0;
    cam_early = 0; done_cnt = 0; aborted_cnt = 0; sync_falls = 0; sync_phase = 0;
    exp_cam_len = 0; exp_galvo_len = 0;
    cam_prev = 1'b0; galvo_prev = 1'b0; ack_galvo_prev = 1'b0; ack_pending = 1'b0; sync_en = 1'b1;
  end

  // free-running VGA sync: SYNC_HIGH cycles high every SYNC_PERIOD cycles
  initial forever begin
    @(negedge iCLK);
    if (sync_en) begin
      if (sync_phase == 0)
        iVGA_FRAME_SYNC = 1'b1;
      else if (sync_phase == SYNC_HIGH) begin
        iVGA_FRAME_SYNC = 1'b0;
        sync_falls++;
      end
      sync_phase = (sync_phase + 1) % SYNC_PERIOD;
    end
  end

  // output monitor: counts pulses, checks pulse lengths and camera-before-ack ordering
  initial forever begin
    @(negedge iCLK);
    if (oCAMERA_TRIGGER) begin
      if (!cam_prev) begin
        cam_rise++;
        if (ack_pending) cam_early++;
      end
      cam_len++;
    end else if (cam_prev) begin
      if (cam_len != exp_cam_len) cam_bad++;
      cam_len = 0;
    end
    if (oGALVO_CHANGE_TRIGGER) begin
      if (!galvo_prev) begin
        galvo_rise++;
        ack_pending = 1'b1;
      end
      galvo_len++;
    end else if (galvo_prev) begin
      if (galvo_len != exp_galvo_len) galvo_bad++;
      galvo_len = 0;
    end
    if (oDONE) done_cnt++;
    if (oABORTED) aborted_cnt++;
    cam_prev   = oCAMERA_TRIGGER;
    galvo_prev = oGALVO_CHANGE_TRIGGER;
  end

  // galvo model: acknowledges each move ACK_DELAY cycles after its trigger rises
  initial forever begin
    @(negedge iCLK);
    if (oGALVO_CHANGE_TRIGGER && !ack_galvo_prev) begin
      repeat (ACK_DELAY) @(negedge iCLK);
      ack_pending = 1'b0;
      iGALVO_ACK  = 1'b1;
      @(negedge iCLK);
      iGALVO_ACK  = 1'b0;
    end
    ack_galvo_prev = oGALVO_CHANGE_TRIGGER;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, got hang, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic clearCounts();
    cam_rise = 0; galvo_rise = 0; cam_bad = 0; galvo_bad = 0; cam_early = 0;
    done_cnt = 0; aborted_cnt = 0; cam_len = 0; galvo_len = 0; ack_pending = 1'b0;
  endtask

  task automatic setInputs(input run_vec_t v);
    iNUM_SLM_IMAGES          = IMG_W'(v.images);
    iCYCLES_PER_IMAGE        = CYC_W'(v.cycles);
    iNUM_GALVO_POSITIONS     = POS_W'(v.positions);
    iSETTLE_FRAMES           = 4'(v.settle);
    iCAMERA_TRIGGER_MILLISEC = MS_W'(v.cam_ms);
    iGALVO_TRIGGER_MILLISEC  = MS_W'(v.galvo_ms);
    exp_cam_len              = v.exp_cam_len;
    exp_galvo_len            = v.exp_galvo_len;
  endtask

  task automatic pulseTrigger(input logic [1:0] trig);
    @(negedge iCLK);
    iTRIG_WITH_GALVO    = trig[1];
    iTRIG_WITHOUT_GALVO = trig[0];
    @(negedge iCLK);
    iTRIG_WITH_GALVO    = 1'b0;
    iTRIG_WITHOUT_GALVO = 1'b0;
  endtask

  task automatic waitDone(input int limit);
    for (int i = 0; i < limit && done_cnt == 0; i++) @(negedge iCLK);
  endtask

  task automatic applyStimulus(input run_vec_t v, input string tag);
    setInputs(v);
    clearCounts();
    pulseTrigger(v.trig);
    waitDone(RUN_TIMEOUT);
    repeat (5) @(negedge iCLK);
    checkOutput({tag, " cam pulses"}, cam_rise, v.exp_cam);
    checkOutput({tag, " galvo pulses"}, galvo_rise, v.exp_galvo);
    checkOutput({tag, " cam bad lengths"}, cam_bad, 0);
    checkOutput({tag, " galvo bad lengths"}, galvo_bad, 0);
    checkOutput({tag, " cam before ack"}, cam_early, 0);
    checkOutput({tag, " done pulses"}, done_cnt, 1);
    checkOutput({tag, " final frame"}, longint'(oCURRENT_DISPLAY_FRAME_ID), v.exp_frame);
    checkOutput({tag, " final pos"}, longint'(oGALVO_POSITION), v.exp_pos);
    checkOutput({tag, " busy after"}, longint'(oBUSY), 0);
  endtask

  initial begin
    run_vec_t hv;
    //            trig   img cyc pos set cam gal  ecam egal clen glen frm pos
    vecs[0] = '{2'b01,   3,  2,  5,  0,  1,  1,   3,   0,  10,  10,  2,  0};
    vecs[1] = '{2'b10,   2,  2,  2,  0,  1,  2,   4,   2,  10,  20,  1,  1};
    vecs[2] = '{2'b01,   1,  1,  0,  1,  3,  1,   1,   0,  30,  10,  0,  0};
    vecs[3] = '{2'b01,   2,  1,  0,  0,  0,  1,   0,   0,   0,  10,  1,  0};
    vecs[4] = '{2'b10,   2,  1,  0,  0,  1,  1,   0,   0,  10,  10,  0,  0};
    vecs[5] = '{2'b11,   1,  1,  1,  0,  2,  1,   1,   1,  20,  10,  0,  0};
    vecs[6] = '{2'b01,   4,  0,  1,  0,  1,  1,   0,   0,  10,  10,  0,  0};
    vecs[7] = '{2'b10,   1,  1,  3,  0,  1,  1,   3,   3,  10,  10,  0,  2};

    repeat (4) @(negedge iCLK);
    iRST = 1'b0;
    @(negedge iCLK);
    checkOutput("reset cam", longint'(oCAMERA_TRIGGER), 0);
    checkOutput("reset galvo", longint'(oGALVO_CHANGE_TRIGGER), 0);
    checkOutput("reset frame", longint'(oCURRENT_DISPLAY_FRAME_ID), 0);
    checkOutput("reset pos", longint'(oGALVO_POSITION), 0);
    checkOutput("reset busy", longint'(oBUSY), 0);
    checkOutput("reset done", longint'(oDONE), 0);
    checkOutput("reset aborted", longint'(oABORTED), 0);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // zero image count: busy for LATCH and FINISH only, done in the third cycle
    hv = vecs[0];
    hv.images = 0;
    setInputs(hv);
    clearCounts();
    @(negedge iCLK);
    iTRIG_WITHOUT_GALVO = 1'b1;
    @(negedge iCLK);
    iTRIG_WITHOUT_GALVO = 1'b0;
    checkOutput("zero c1 busy", longint'(oBUSY), 1);
    checkOutput("zero c1 done", longint'(oDONE), 0);
    @(negedge iCLK);
    checkOutput("zero c2 busy", longint'(oBUSY), 1);
    checkOutput("zero c2 done", longint'(oDONE), 0);
    @(negedge iCLK);
    checkOutput("zero c3 busy", longint'(oBUSY), 0);
    checkOutput("zero c3 done", longint'(oDONE), 1);
    @(negedge iCLK);
    checkOutput("zero c4 done", longint'(oDONE), 0);
    checkOutput("zero cam pulses", cam_rise, 0);

    // abort in the middle of the second camera pulse
    hv = vecs[0];
    hv.cam_ms = 5;
    hv.exp_cam_len = 50;
    setInputs(hv);
    clearCounts();
    pulseTrigger(2'b01);
    for (int i = 0; i < 5000 && cam_rise < 2; i++) @(negedge iCLK);
    repeat (10) @(negedge iCLK);
    checkOutput("abort cam before", longint'(oCAMERA_TRIGGER), 1);
    checkOutput("abort frame before", longint'(oCURRENT_DISPLAY_FRAME_ID), 1);
    iABORT = 1'b1;
    @(negedge iCLK);
    iABORT = 1'b0;
    checkOutput("abort cam dropped", longint'(oCAMERA_TRIGGER), 0);
    checkOutput("abort pulse", longint'(oABORTED), 1);
    checkOutput("abort busy", longint'(oBUSY), 0);
    checkOutput("abort frame", longint'(oCURRENT_DISPLAY_FRAME_ID), 0);
    checkOutput("abort pos", longint'(oGALVO_POSITION), 0);
    @(negedge iCLK);
    checkOutput("abort pulse width", longint'(oABORTED), 0);
    iABORT = 1'b1;
    repeat (2) @(negedge iCLK);
    iABORT = 1'b0;
    checkOutput("abort in idle", longint'(oABORTED), 0);
    checkOutput("abort done count", done_cnt, 0);
    applyStimulus(vecs[0], "rerun");

    // settle=3: camera waits for the 4th sync after the image change
    hv = vecs[0];
    hv.images = 2;
    hv.cycles = 1;
    hv.settle = 3;
    setInputs(hv);
    clearCounts();
    pulseTrigger(2'b01);
    for (int i = 0; i < 5000 && oCURRENT_DISPLAY_FRAME_ID != 1; i++) @(negedge iCLK);
    sync_falls = 0;
    for (int i = 0; i < 5000 && cam_rise < 2; i++) @(negedge iCLK);
    checkOutput("settle syncs before cam", sync_falls, 4);
    waitDone(RUN_TIMEOUT);
    checkOutput("settle done", done_cnt, 1);

    // a 3-cycle low glitch inside a sync pulse must not make an event
    sync_en = 1'b0;
    @(negedge iCLK);
    iVGA_FRAME_SYNC = 1'b0;
    repeat (30) @(negedge iCLK);
    hv = vecs[2];
    hv.settle = 0;
    hv.cam_ms = 1;
    hv.exp_cam_len = 10;
    setInputs(hv);
    clearCounts();
    pulseTrigger(2'b01);
    iVGA_FRAME_SYNC = 1'b1;
    repeat (20) @(negedge iCLK);
    iVGA_FRAME_SYNC = 1'b0;
    repeat (3) @(negedge iCLK);
    iVGA_FRAME_SYNC = 1'b1;
    repeat (20) @(negedge iCLK);
    iVGA_FRAME_SYNC = 1'b0;
    repeat (40) @(negedge iCLK);
    checkOutput("glitch cam pulses", cam_rise, 1);
    checkOutput("glitch no early done", done_cnt, 0);
    iVGA_FRAME_SYNC = 1'b1;
    repeat (20) @(negedge iCLK);
    iVGA_FRAME_SYNC = 1'b0;
    repeat (40) @(negedge iCLK);
    checkOutput("glitch done", done_cnt, 1);
    sync_en = 1'b1;

`ifdef SCAN_SEQ_CAM_READY_EN
    // camera held not-ready for 1000 cycles delays the camera pulse
    setInputs(hv);
    clearCounts();
    iCAMERA_READY = 1'b0;
    pulseTrigger(2'b01);
    repeat (1000) @(negedge iCLK);
    checkOutput("ready held cam", cam_rise, 0);
    iCAMERA_READY = 1'b1;
    for (int i = 0; i < 50 && cam_rise == 0; i++) @(negedge iCLK);
    checkOutput("ready cam after", cam_rise, 1);
    waitDone(RUN_TIMEOUT);
    checkOutput("ready done", done_cnt, 1);
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
